// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects, FSM states
// and the shadow-slot record tracking one in-flight destination register.
package hazard_pkg;

    localparam int HZ_RD_W = 5;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_WB   = 2'd1,
        FWD_MEM  = 2'd2
    } fwd_sel_e;

    typedef enum logic [1:0] {
        RUN,
        LOAD_STALL,
        MEM_WAIT
    } hz_state_e;

    typedef struct packed {
        logic               valid;
        logic [HZ_RD_W-1:0] rd;
        logic               wren;
        logic               load;
    } hz_slot_t;

    localparam hz_slot_t SLOT_EMPTY = '0;

    // A producer one slot ahead will sit in MEM when the consumer reaches EX,
    // so it wins over the older producer two slots ahead.
    function automatic fwd_sel_e fwd_pick(hz_slot_t ex_s, hz_slot_t mem_s,
                                          logic [HZ_RD_W-1:0] rs, logic used);
        fwd_sel_e sel;
        sel = FWD_NONE;
        if (used && rs != '0) begin
            if (ex_s.valid && ex_s.wren && ex_s.rd == rs)
                sel = FWD_MEM;
            else if (mem_s.valid && mem_s.wren && mem_s.rd == rs)
                sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard controller
// (slave). Counter outputs exist only when HAZARD_PERF_CNT_EN is defined.
interface hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5
`ifdef HAZARD_PERF_CNT_EN
    , parameter int CNT_W = 32
`endif
);
    logic                  i_id_valid;
    logic [REG_ADDR_W-1:0] i_id_rs1_addr;
    logic [REG_ADDR_W-1:0] i_id_rs2_addr;
    logic                  i_id_rs1_used;
    logic                  i_id_rs2_used;
    logic [REG_ADDR_W-1:0] i_id_rd_addr;
    logic                  i_id_rd_wren;
    logic                  i_id_mem_rden;
    logic                  i_ex_brc_pc_sel;
    logic                  i_mem_stall;
    logic [1:0]            o_forward_A;
    logic [1:0]            o_forward_B;
    logic                  o_pc_stall;
    logic                  o_if_id_stall;
    logic                  o_if_id_flush;
    logic                  o_id_ex_flush;
    logic                  o_ex_mem_stall;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0]      o_stall_cnt;
    logic [CNT_W-1:0]      o_flush_cnt;
`endif

    modport master (
        output i_id_valid, i_id_rs1_addr, i_id_rs2_addr, i_id_rs1_used, i_id_rs2_used,
               i_id_rd_addr, i_id_rd_wren, i_id_mem_rden, i_ex_brc_pc_sel, i_mem_stall,
        input  o_forward_A, o_forward_B, o_pc_stall, o_if_id_stall, o_if_id_flush,
               o_id_ex_flush, o_ex_mem_stall
`ifdef HAZARD_PERF_CNT_EN
        , input o_stall_cnt, o_flush_cnt
`endif
    );

    modport slave (
        input  i_id_valid, i_id_rs1_addr, i_id_rs2_addr, i_id_rs1_used, i_id_rs2_used,
               i_id_rd_addr, i_id_rd_wren, i_id_mem_rden, i_ex_brc_pc_sel, i_mem_stall,
        output o_forward_A, o_forward_B, o_pc_stall, o_if_id_stall, o_if_id_flush,
               o_id_ex_flush, o_ex_mem_stall
`ifdef HAZARD_PERF_CNT_EN
        , output o_stall_cnt, o_flush_cnt
`endif
    );
endinterface

// File: rtl/hazard_slot_pipe.sv
// Three-slot shadow of in-flight destination registers (EX, MEM, WB), shifted
// in lockstep with the real pipeline: advance shifts, bubble inserts an empty EX slot.
module hazard_slot_pipe
    import hazard_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     advance,
    input  logic     bubble,
    input  hz_slot_t id_slot,
    output hz_slot_t ex_q,
    output hz_slot_t mem_q,
    output hz_slot_t wb_q
);

    // NOTE: these are control flops, not a memory array, so they take the async
    // reset; a stale valid bit after reset would create phantom hazards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q  <= SLOT_EMPTY;
            mem_q <= SLOT_EMPTY;
            wb_q  <= SLOT_EMPTY;
        end else if (advance) begin
            // NOTE: non-blocking assignments make this a true shift; each slot
            // samples its neighbour's pre-edge value regardless of statement order.
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= bubble ? SLOT_EMPTY : id_slot;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I core: forwarding selects, load-use
// bubbles, redirect flushes and memory-wait freezes. Optional HAZARD_PERF_CNT_EN.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5
`ifdef HAZARD_PERF_CNT_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic          i_clk,
    input  logic          i_reset,
    hazard_ctrl_if.slave  bus
);

    hz_state_e             state_q, state_d;
    fwd_sel_e              fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;
    hz_slot_t              ex_q, mem_q, wb_q, id_slot;
    logic [REG_ADDR_W-1:0] rs1, rs2, rd;
    logic                  freeze, redirect, load_hit, load_use, bubble;

    assign rs1 = bus.i_id_rs1_addr;
    assign rs2 = bus.i_id_rs2_addr;
    assign rd  = bus.i_id_rd_addr;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        freeze   = bus.i_mem_stall;
        redirect = bus.i_ex_brc_pc_sel & ~freeze;
        load_hit = bus.i_id_valid & ex_q.valid & ex_q.load & (ex_q.rd != '0) &
                   ((bus.i_id_rs1_used & (ex_q.rd == rs1)) |
                    (bus.i_id_rs2_used & (ex_q.rd == rs2)));
        // A redirect squashes the would-be stalled instruction, so it wins.
        load_use = load_hit & ~redirect & ~freeze & (state_q != LOAD_STALL);
        bubble   = redirect | load_use | ~bus.i_id_valid;

        id_slot = '{valid: bus.i_id_valid, rd: rd, wren: bus.i_id_rd_wren,
                    load: bus.i_id_mem_rden};
        fwd_a_d = bubble ? FWD_NONE : fwd_pick(ex_q, mem_q, rs1, bus.i_id_rs1_used);
        fwd_b_d = bubble ? FWD_NONE : fwd_pick(ex_q, mem_q, rs2, bus.i_id_rs2_used);

        state_d = RUN;
        if (freeze)
            state_d = MEM_WAIT;
        else if (load_use)
            state_d = LOAD_STALL;

        bus.o_pc_stall     = freeze | load_use;
        bus.o_if_id_stall  = freeze | load_use;
        bus.o_if_id_flush  = redirect;
        bus.o_id_ex_flush  = redirect | load_use;
        bus.o_ex_mem_stall = freeze;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= RUN;
            fwd_a_q <= FWD_NONE;
            fwd_b_q <= FWD_NONE;
        end else begin
            state_q <= state_d;
            if (!freeze) begin
                fwd_a_q <= fwd_a_d;
                fwd_b_q <= fwd_b_d;
            end
        end
    end

    assign bus.o_forward_A = fwd_a_q;
    assign bus.o_forward_B = fwd_b_q;

    hazard_slot_pipe u_slots (
        .clk     (i_clk),
        .rst     (i_reset),
        .advance (~freeze),
        .bubble  (bubble),
        .id_slot (id_slot),
        .ex_q    (ex_q),
        .mem_q   (mem_q),
        .wb_q    (wb_q)
    );

    // The register file is write-first, so the WB slot and the MEM load flag never steer anything.
    logic unused_slot_bits;
    assign unused_slot_bits = ^{wb_q, mem_q.load};

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if ((freeze || load_use) && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (redirect && flush_cnt_q != '1)
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign bus.o_stall_cnt = stall_cnt_q;
    assign bus.o_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed table-driven bench for hazard_ctrl plus hand-written reset/freeze sequences.
module tb_hazard_ctrl;
    logic clk;
    logic rst;

    hazard_ctrl_if bus ();

    hazard_ctrl dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctl bits: {pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_mem_stall}
    localparam logic [4:0] C_NONE = 5'b00000;
    localparam logic [4:0] C_LU   = 5'b11010;
    localparam logic [4:0] C_RD   = 5'b00110;
    localparam logic [4:0] C_MW   = 5'b11001;

    typedef struct {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
        logic       brc;
        logic       ms;
        logic [4:0] ctl;
        logic [1:0] ea;
        logic [1:0] eb;
    } vec_t;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    function automatic vec_t mk(logic v, logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                                logic [4:0] rd, logic wr, logic ld, logic brc, logic ms,
                                logic [4:0] ctl, logic [1:0] ea, logic [1:0] eb);
        vec_t r;
        r = '{v, rs1, rs2, u1, u2, rd, wr, ld, brc, ms, ctl, ea, eb};
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t r);
        bus.i_id_valid      = r.v;
        bus.i_id_rs1_addr   = r.rs1;
        bus.i_id_rs2_addr   = r.rs2;
        bus.i_id_rs1_used   = r.u1;
        bus.i_id_rs2_used   = r.u2;
        bus.i_id_rd_addr    = r.rd;
        bus.i_id_rd_wren    = r.wr;
        bus.i_id_mem_rden   = r.ld;
        bus.i_ex_brc_pc_sel = r.brc;
        bus.i_mem_stall     = r.ms;
    endtask

    function automatic logic [4:0] ctl_now();
        return {bus.o_pc_stall, bus.o_if_id_stall, bus.o_if_id_flush,
                bus.o_id_ex_flush, bus.o_ex_mem_stall};
    endfunction

    initial begin
        // add x5,x1,x2 ; sub x6,x5,x3 -> MEM forward on A
        vecs.push_back(mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, C_NONE, 0, 0));
        vecs.push_back(mk(1, 5, 3, 1, 1, 6, 1, 0, 0, 0, C_NONE, 2, 0));
        // add x5 ; nop ; or x7,x4,x5 -> WB forward on B
        vecs.push_back(mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, C_NONE, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 0));
        vecs.push_back(mk(1, 4, 5, 1, 1, 7, 1, 0, 0, 0, C_NONE, 0, 1));
        // lw x8 ; add x9,x8,x8 (stall, bubble) ; retried add gets WB on both
        vecs.push_back(mk(1, 1, 0, 1, 0, 8, 1, 1, 0, 0, C_NONE, 0, 0));
        vecs.push_back(mk(1, 8, 8, 1, 1, 9, 1, 0, 0, 0, C_LU, 0, 0));
        vecs.push_back(mk(1, 8, 8, 1, 1, 9, 1, 0, 0, 0, C_NONE, 1, 1));
        // addi x0,x0,1 ; add x3,x0,x0 -> x0 never forwards
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 1, 0, 0, 0, C_NONE, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 1, 3, 1, 0, 0, 0, C_NONE, 0, 0));
        // lw x10 ; redirect together with load-use ; redirect over a WB dependency
        vecs.push_back(mk(1, 2, 0, 1, 0, 10, 1, 1, 0, 0, C_NONE, 0, 0));
        vecs.push_back(mk(1, 10, 10, 1, 1, 11, 1, 0, 1, 0, C_RD, 0, 0));
        vecs.push_back(mk(1, 10, 0, 1, 1, 13, 1, 0, 1, 0, C_RD, 0, 0));
        // lw x10 now only in WB slot -> no forward
        vecs.push_back(mk(1, 10, 10, 1, 1, 14, 1, 0, 0, 0, C_NONE, 0, 0));
        // add x15,x14,x2 ; then 3-cycle freeze with pending redirect, flush on release
        vecs.push_back(mk(1, 14, 2, 1, 1, 15, 1, 0, 0, 0, C_NONE, 2, 0));
        vecs.push_back(mk(1, 15, 14, 1, 1, 16, 1, 0, 1, 1, C_MW, 2, 0));
        vecs.push_back(mk(1, 15, 14, 1, 1, 16, 1, 0, 1, 1, C_MW, 2, 0));
        vecs.push_back(mk(1, 15, 14, 1, 1, 16, 1, 0, 1, 1, C_MW, 2, 0));
        vecs.push_back(mk(1, 15, 14, 1, 1, 16, 1, 0, 1, 0, C_RD, 0, 0));
        // slots held during freeze: add x15 is now in the MEM slot
        vecs.push_back(mk(1, 15, 0, 1, 1, 17, 1, 0, 0, 0, C_NONE, 1, 0));
        // lw x0 ; add x1,x0,x0 -> load into x0 causes no stall
        vecs.push_back(mk(1, 1, 0, 1, 0, 0, 1, 1, 0, 0, C_NONE, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 1, 1, 1, 0, 0, 0, C_NONE, 0, 0));

        rst = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 0));
        #12;
        check("reset fwd_a", int'(bus.o_forward_A), 0);
        check("reset fwd_b", int'(bus.o_forward_B), 0);
        check("reset ctl", int'(ctl_now()), int'(C_NONE));
`ifdef HAZARD_PERF_CNT_EN
        check("reset stall_cnt", int'(bus.o_stall_cnt), 0);
        check("reset flush_cnt", int'(bus.o_flush_cnt), 0);
`endif
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check($sformatf("row%0d ctl", i), int'(ctl_now()), int'(vecs[i].ctl));
            @(posedge clk);
            #1;
            check($sformatf("row%0d fwd_a", i), int'(bus.o_forward_A), int'(vecs[i].ea));
            check($sformatf("row%0d fwd_b", i), int'(bus.o_forward_B), int'(vecs[i].eb));
        end

`ifdef HAZARD_PERF_CNT_EN
        // one load-use + three freeze cycles; three redirect flushes
        check("stall_cnt total", int'(bus.o_stall_cnt), 4);
        check("flush_cnt total", int'(bus.o_flush_cnt), 3);
`endif

        // Async reset in the middle of a freeze with live forward selects.
        @(negedge clk);
        drive(mk(1, 1, 2, 1, 1, 20, 1, 0, 0, 0, C_NONE, 0, 0));
        @(negedge clk);
        drive(mk(1, 20, 20, 1, 1, 21, 1, 0, 0, 0, C_NONE, 0, 0));
        @(posedge clk);
        #1;
        check("pre-reset fwd_a", int'(bus.o_forward_A), 2);
        @(negedge clk);
        bus.i_mem_stall = 1'b1;
        #1;
        check("pre-reset freeze", int'(ctl_now()), int'(C_MW));
        #1;
        rst = 1'b1;
        #1;
        check("async reset fwd_a", int'(bus.o_forward_A), 0);
        check("async reset fwd_b", int'(bus.o_forward_B), 0);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 0));
        #1;
        check("async reset ctl", int'(ctl_now()), int'(C_NONE));
`ifdef HAZARD_PERF_CNT_EN
        check("async reset stall_cnt", int'(bus.o_stall_cnt), 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        // or x22,x21,x20: both producers were in flight before reset, now forgotten
        drive(mk(1, 21, 20, 1, 1, 22, 1, 0, 0, 0, C_NONE, 0, 0));
        #1;
        check("post-reset ctl", int'(ctl_now()), int'(C_NONE));
        @(posedge clk);
        #1;
        check("post-reset fwd_a", int'(bus.o_forward_A), 0);
        check("post-reset fwd_b", int'(bus.o_forward_B), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RV32I core; drives the execute stage's operand-forwarding selects and all pipeline-register stall/flush controls.
- Keeps its own shadow pipeline of in-flight destination registers (EX/MEM/WB slots) and resolves hazards in ID.
- Registers forwarding selects at the ID->EX boundary so they arrive aligned with the instruction in EX.
- Sequences load-use bubbles, branch/jump redirect flushes and data-memory wait freezes.

Parameters:
REG_ADDR_W, 5, register-file address width
CNT_W, 32, width of optional performance counters

Ports:
i_clk  in  1  core clock
i_reset  in  1  asynchronous, active-high reset
i_id_valid  in  1  ID holds a real instruction
i_id_rs1_addr  in  REG_ADDR_W  ID source 1
i_id_rs2_addr  in  REG_ADDR_W  ID source 2
i_id_rs1_used  in  1  ID instruction reads rs1 (not PC-relative/LUI)
i_id_rs2_used  in  1  ID instruction reads rs2
i_id_rd_addr  in  REG_ADDR_W  ID destination
i_id_rd_wren  in  1  ID instruction writes rd
i_id_mem_rden  in  1  ID instruction is a load
i_ex_brc_pc_sel  in  1  EX instruction redirects PC (taken branch, JAL, JALR)
i_mem_stall  in  1  data memory not ready; freeze entire pipeline
o_forward_A  out  2  EX operand A select: 0 none, 1 WB, 2 MEM; 3 never driven
o_forward_B  out  2  EX operand B select, same encoding
o_pc_stall  out  1  hold PC
o_if_id_stall  out  1  hold IF/ID register
o_if_id_flush  out  1  clear IF/ID to bubble
o_id_ex_flush  out  1  clear ID/EX to bubble
o_ex_mem_stall  out  1  hold EX/MEM and MEM/WB registers

Behaviour:
- Reset: all slots invalid, state RUN, o_forward_A/B = 0, all stall/flush outputs 0.
- Shadow slots ex_q, mem_q, wb_q each hold {valid, rd, wren, load}. On advance: wb_q<=mem_q, mem_q<=ex_q, ex_q<=ID info (or invalid if bubble/flush).
- Forward decision for each used source rs, computed combinationally in ID:
  - 2 if ex_q.valid & ex_q.wren & rd==rs (this producer is in MEM when the consumer reaches EX);
  - else 1 if mem_q.valid & mem_q.wren & rd==rs;
  - else 0. MEM has priority over WB.
  - rs==0 or source unused -> 0. The register file is write-first, so the wb_q slot never forwards.
  - Result is registered into o_forward_A/B on ID->EX advance; it is 0 when a bubble or flush enters EX.
- Load-use: ex_q.valid & ex_q.load & ex_q.rd!=0 & rd matches a used source of a valid ID instruction.
  - Response: o_pc_stall=o_if_id_stall=1 and o_id_ex_flush=1 for exactly one cycle; slots advance with a bubble into ex_q.
  - The retried instruction then sees the load in mem_q and receives FWD_WB.
- FSM states: RUN, LOAD_STALL, MEM_WAIT.
  - RUN -> LOAD_STALL on load-use. LOAD_STALL is a single cycle, then returns to RUN.
  - Any state -> MEM_WAIT while i_mem_stall=1. MEM_WAIT -> RUN on the first cycle i_mem_stall=0.
- Redirect: i_ex_brc_pc_sel=1 (not in MEM_WAIT) -> o_if_id_flush=o_id_ex_flush=1 for one cycle; bubble into ex_q; o_forward_A/B<=0.
  - Redirect beats load-use in the same cycle: the stall is suppressed because the stalled instruction is squashed.
- MEM_WAIT:
  - o_pc_stall, o_if_id_stall and o_ex_mem_stall are high; all slots and o_forward_A/B hold.
  - Flush outputs are forced 0. A pending redirect stays asserted by EX and is acted on in the cycle after release.
- i_id_valid=0: ID is treated as a bubble (no hazard; ex_q gets invalid on advance).
- Reset asserted mid-stall returns everything to reset values asynchronously.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: adds o_stall_cnt and o_flush_cnt (each CNT_W, out).
  - o_stall_cnt counts load-use plus MEM_WAIT cycles; o_flush_cnt counts redirect flushes.
  - Both counters saturate at all-ones and clear on reset.
- Undefined: ports and counters are absent.

Decomposition:
- Shared package hazard_pkg holds:
  - fwd_sel_e (FWD_NONE=0, FWD_WB=1, FWD_MEM=2);
  - hz_state_e (RUN, LOAD_STALL, MEM_WAIT);
  - hz_slot_t struct {valid, rd, wren, load}.
- The execute stage imports fwd_sel_e.
- One sub-module: hazard_slot_pipe (three-slot shadow shift register with advance/bubble/hold controls).

Test Plan:
- add x5,x1,x2 then sub x6,x5,x3 -> the sub in EX has o_forward_A=2, o_forward_B=0, no stall.
- add x5; nop; or x7,x4,x5 -> the or in EX has o_forward_B=1.
- lw x8,0(x1) then add x9,x8,x8 -> one cycle of o_pc_stall=o_if_id_stall=o_id_ex_flush=1; the add in EX has o_forward_A=o_forward_B=1.
- addi x0,x0,1 then add x3,x0,x0 -> no forward (selects 0), no stall.
- i_ex_brc_pc_sel=1 together with a load-use -> o_if_id_flush=o_id_ex_flush=1, o_pc_stall=0, next-cycle forward selects 0.
- i_mem_stall high 3 cycles during a pending redirect -> stalls high and flushes 0 for 3 cycles, flush on the 4th; with HAZARD_PERF_CNT_EN, o_stall_cnt=3 and o_flush_cnt=1.
